// File: rtl/serial_add_sched.sv
// Round-robin front end for one shared 1-bit full-adder cell.
// Grants one of two requesters, adds LSB-first over WIDTH cycles and holds the result.
module serial_add_sched #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_id,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             id_q, id_d;
    logic             last_id_q, last_id_d;
    logic             grant0, grant1;
    logic             fa_sum, fa_cout;

    // On contention, the requester not served last wins.
    assign grant0 = req0_valid && (!req1_valid || last_id_q);
    assign grant1 = req1_valid && (!req0_valid || !last_id_q);

    assign req0_ready = rst_n && (state_q == StIdle) && grant0;
    assign req1_ready = rst_n && (state_q == StIdle) && grant1;

    assign fa_sum  = a_q[0] ^ b_q[0] ^ carry_q;
    assign fa_cout = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_id    = id_q;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        id_d      = id_q;
        last_id_d = last_id_q;
        unique case (state_q)
            StIdle: begin
                if (req0_valid && req0_ready) begin
                    a_d     = req0_a;
                    b_d     = req0_b;
                    carry_d = req0_cin;
                    cnt_d   = '0;
                    id_d    = 1'b0;
                    state_d = StRun;
                end else if (req1_valid && req1_ready) begin
                    a_d     = req1_a;
                    b_d     = req1_b;
                    carry_d = req1_cin;
                    cnt_d   = '0;
                    id_d    = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                // Operands shift right; sum bits enter at the top and land in place after WIDTH steps.
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sum_d   = (sum_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
                carry_d = fa_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cout_d  = fa_cout;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    last_id_d = id_q;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
            id_q      <= 1'b0;
            last_id_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            cout_q    <= cout_d;
            id_q      <= id_d;
            last_id_q <= last_id_d;
        end
    end

endmodule
